// File: rtl/wb_ledwalker_multi.sv
// Pipelined-Wishbone LED walker: a one-hot light steps across NLEDS outputs
// in bounce, up-only or down-only passes, with a programmable step rate, a repeat count and an abort.
module wb_ledwalker_multi #(
    parameter int NLEDS   = 8,
    parameter int CLK_DIV = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_wb_cyc,
    input  logic             i_wb_stb,
    input  logic             i_wb_we,
    input  logic [1:0]       i_wb_addr,
    input  logic [31:0]      i_wb_data,
    output logic             o_wb_stall,
    output logic             o_wb_ack,
    output logic [31:0]      o_wb_data,
    output logic [NLEDS-1:0] o_led,
    output logic             o_busy
);

    localparam logic [0:0]  S_IDLE  = 1'b0;
    localparam logic [0:0]  S_RUN   = 1'b1;
    localparam logic [9:0]  N       = 10'(NLEDS);
    localparam logic [15:0] DIV_RST = 16'(CLK_DIV - 1);

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_DIV    = 2'd1;
    localparam logic [1:0] A_STATUS = 2'd2;
    localparam logic [1:0] A_ABORT  = 2'd3;

    logic [0:0]  state;
    logic [31:0] ctrl;
    logic [15:0] div;
    logic [15:0] run_div;
    logic [15:0] div_cnt;
    logic [1:0]  run_mode;
    logic [7:0]  run_reps;
    logic [7:0]  pass;
    logic [9:0]  pos;
    logic [9:0]  last_pos;
    logic [9:0]  led_idx;
    logic        accept;
    logic        ctrl_wr;
    logic        abort_wr;
    logic        step_tick;

    assign o_busy     = (state == S_RUN);
    // Only a new walk request has to wait; everything else is serviced immediately.
    assign o_wb_stall = o_busy && i_wb_we && (i_wb_addr == A_CTRL);
    assign accept     = i_wb_stb && !o_wb_stall;
    assign ctrl_wr    = accept && i_wb_we && (i_wb_addr == A_CTRL);
    assign abort_wr   = accept && i_wb_we && (i_wb_addr == A_ABORT);
    assign step_tick  = (div_cnt == run_div);

    // pos counts steps within a pass; the LED index is derived from it per mode.
    // NOTE: every output of a combinational block is given a value on every path, so no latch is inferred.
    always_comb begin
        last_pos = 10'd2 * N - 10'd2;
        led_idx  = pos;
        case (run_mode)
            2'd1: begin
                last_pos = N - 10'd1;
                led_idx  = pos;
            end
            2'd2: begin
                last_pos = N - 10'd1;
                led_idx  = N - 10'd1 - pos;
            end
            default: begin
                led_idx = (pos < N) ? pos : (10'd2 * N - 10'd2 - pos);
            end
        endcase
    end

    assign o_led = o_busy ? ({{(NLEDS-1){1'b0}}, 1'b1} << led_idx) : '0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= S_IDLE;
            ctrl     <= '0;
            div      <= DIV_RST;
            run_div  <= '0;
            div_cnt  <= '0;
            run_mode <= '0;
            run_reps <= '0;
            pass     <= '0;
            pos      <= '0;
        end else begin
            if (accept && i_wb_we) begin
                case (i_wb_addr)
                    A_CTRL:  ctrl <= i_wb_data;
                    A_DIV:   div  <= i_wb_data[15:0];
                    default: ;
                endcase
            end

            if (ctrl_wr) begin
                state    <= S_RUN;
                run_mode <= i_wb_data[1:0];
                run_reps <= i_wb_data[15:8];
                run_div  <= div;
                div_cnt  <= '0;
                pos      <= '0;
                pass     <= '0;
            end else if (abort_wr) begin
                state <= S_IDLE;
            end else if (o_busy) begin
                if (step_tick) begin
                    div_cnt <= '0;
                    if (pos == last_pos) begin
                        if (pass == run_reps) begin
                            state <= S_IDLE;
                        end else begin
                            pos  <= '0;
                            pass <= pass + 8'd1;
                        end
                    end else begin
                        pos <= pos + 10'd1;
                    end
                end else begin
                    div_cnt <= div_cnt + 16'd1;
                end
            end
        end
    end

    // Ack and read data are registered together; data is zero on cycles without a read ack.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_wb_ack  <= 1'b0;
            o_wb_data <= '0;
        end else begin
            o_wb_ack  <= accept && i_wb_cyc;
            o_wb_data <= '0;
            if (accept && i_wb_cyc && !i_wb_we) begin
                case (i_wb_addr)
                    A_CTRL:   o_wb_data <= ctrl;
                    A_DIV:    o_wb_data <= {16'd0, div};
                    A_STATUS: o_wb_data <= {o_busy, 7'd0, pass, 8'd0, pos[7:0]};
                    default:  o_wb_data <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wb_ledwalker_multi.sv
// Directed bench for wb_ledwalker_multi (NLEDS=4, CLK_DIV=1); bus responses go
// through an expected-data queue checked by an independent ack monitor.
module tb_wb_ledwalker_multi;

    localparam int NLEDS = 4;

    logic             i_clk = 1'b0;
    logic             i_reset;
    logic             i_wb_cyc;
    logic             i_wb_stb;
    logic             i_wb_we;
    logic [1:0]       i_wb_addr;
    logic [31:0]      i_wb_data;
    logic             o_wb_stall;
    logic             o_wb_ack;
    logic [31:0]      o_wb_data;
    logic [NLEDS-1:0] o_led;
    logic             o_busy;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    wb_ledwalker_multi #(.NLEDS(NLEDS), .CLK_DIV(1)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_wb_cyc   (i_wb_cyc),
        .i_wb_stb   (i_wb_stb),
        .i_wb_we    (i_wb_we),
        .i_wb_addr  (i_wb_addr),
        .i_wb_data  (i_wb_data),
        .o_wb_stall (o_wb_stall),
        .o_wb_ack   (o_wb_ack),
        .o_wb_data  (o_wb_data),
        .o_led      (o_led),
        .o_busy     (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: every ack must match the oldest queued expectation.
    always @(negedge i_clk) begin
        if (o_wb_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                check("ack_data", o_wb_data, exp_q.pop_front());
            end
        end
    end

    // Issues one request starting at a negedge; returns just after the accepting edge.
    task automatic bus(input logic we, input logic [1:0] addr, input logic [31:0] data,
                       input logic [31:0] expected, output int stalls);
        @(negedge i_clk);
        i_wb_cyc  = 1'b1;
        i_wb_stb  = 1'b1;
        i_wb_we   = we;
        i_wb_addr = addr;
        i_wb_data = data;
        stalls    = 0;
        #1;
        while (o_wb_stall && stalls < 200) begin
            @(negedge i_clk);
            #1;
            stalls++;
        end
        if (stalls >= 200) check("stall_timeout", 32'd1, 32'd0);
        exp_q.push_back(expected);
        @(posedge i_clk);
        #1;
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        i_wb_we  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (o_busy && n < 2000) begin
            @(negedge i_clk);
            n++;
        end
        check(name, {31'd0, o_busy}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        logic [3:0] bounce_pat [7];
        bounce_pat = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1};

        i_reset = 1'b1; i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
        i_wb_addr = 2'd0; i_wb_data = 32'd0;
        repeat (3) @(posedge i_clk);
        #1 i_reset = 1'b0;
        @(negedge i_clk);
        check("reset_led",   {28'd0, o_led}, 32'd0);
        check("reset_busy",  {31'd0, o_busy}, 32'd0);
        check("reset_ack",   {31'd0, o_wb_ack}, 32'd0);
        check("reset_stall", {31'd0, o_wb_stall}, 32'd0);

        // 1: bounce, one pass, DIV=0
        bus(1'b1, 2'd0, 32'h0000_0000, 32'd0, st);
        for (int k = 0; k < 7; k++) begin
            @(negedge i_clk);
            check($sformatf("t1_led%0d", k), {28'd0, o_led}, {28'd0, bounce_pat[k]});
            check($sformatf("t1_busy%0d", k), {31'd0, o_busy}, 32'd1);
        end
        @(negedge i_clk);
        check("t1_end_led",  {28'd0, o_led}, 32'd0);
        check("t1_end_busy", {31'd0, o_busy}, 32'd0);

        // 2: DIV=2, up-only, two passes -> 24 busy clocks
        bus(1'b1, 2'd1, 32'd2, 32'd0, st);
        bus(1'b1, 2'd0, 32'h0000_0101, 32'd0, st);
        for (int k = 0; k < 24; k++) begin
            @(negedge i_clk);
            check($sformatf("t2_led%0d", k), {28'd0, o_led}, 32'd1 << ((k / 3) % 4));
            check($sformatf("t2_busy%0d", k), {31'd0, o_busy}, 32'd1);
        end
        @(negedge i_clk);
        check("t2_end_busy", {31'd0, o_busy}, 32'd0);
        bus(1'b0, 2'd0, 32'd0, 32'h0000_0101, st);

        // 3: CTRL write during a 21-clock bounce walk stalls until busy falls
        bus(1'b1, 2'd0, 32'h0000_0000, 32'd0, st);
        bus(1'b1, 2'd0, 32'h0000_0002, 32'd0, st);
        check("t3_stalls", st, 32'd21);
        @(negedge i_clk);
        check("t3_new_led",  {28'd0, o_led}, 32'h8);
        check("t3_new_busy", {31'd0, o_busy}, 32'd1);
        wait_idle("t3_idle");

        // 4: ABORT at the 3rd step
        bus(1'b1, 2'd1, 32'd0, 32'd0, st);
        bus(1'b1, 2'd0, 32'h0000_0000, 32'd0, st);
        @(negedge i_clk);
        @(negedge i_clk);
        check("t4_step2_led", {28'd0, o_led}, 32'h2);
        bus(1'b1, 2'd3, 32'd0, 32'd0, st);
        check("t4_stalls", st, 32'd0);
        @(negedge i_clk);
        check("t4_led",  {28'd0, o_led}, 32'd0);
        check("t4_busy", {31'd0, o_busy}, 32'd0);
        bus(1'b1, 2'd3, 32'd0, 32'd0, st);
        @(negedge i_clk);
        check("t4_idle_abort_busy", {31'd0, o_busy}, 32'd0);

        // 5: STATUS read at step 5 of pass 0, then register read-back
        bus(1'b1, 2'd0, 32'h0000_0000, 32'd0, st);
        repeat (5) @(negedge i_clk);
        bus(1'b0, 2'd2, 32'd0, 32'h8000_0005, st);
        wait_idle("t5_idle");
        bus(1'b1, 2'd1, 32'h0000_ABCD, 32'd0, st);
        bus(1'b0, 2'd1, 32'd0, 32'h0000_ABCD, st);
        bus(1'b0, 2'd3, 32'd0, 32'd0, st);
        bus(1'b1, 2'd2, 32'hFFFF_FFFF, 32'd0, st);
        bus(1'b0, 2'd1, 32'd0, 32'h0000_ABCD, st);

        // 6: reset mid-walk with a read pending
        bus(1'b1, 2'd0, 32'h0000_0000, 32'd0, st);
        repeat (3) @(negedge i_clk);
        check("t6_pre_led", {28'd0, o_led}, 32'h1);
        i_reset   = 1'b1;
        i_wb_cyc  = 1'b1;
        i_wb_stb  = 1'b1;
        i_wb_we   = 1'b0;
        i_wb_addr = 2'd1;
        @(posedge i_clk);
        #1;
        i_reset  = 1'b0;
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        @(negedge i_clk);
        check("t6_ack",  {31'd0, o_wb_ack}, 32'd0);
        check("t6_data", o_wb_data, 32'd0);
        check("t6_led",  {28'd0, o_led}, 32'd0);
        check("t6_busy", {31'd0, o_busy}, 32'd0);
        bus(1'b0, 2'd1, 32'd0, 32'd0, st);
        bus(1'b0, 2'd0, 32'd0, 32'd0, st);

        repeat (3) @(negedge i_clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
